keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 matrix keypad. It drives columns one at a time, samples the rows and debounces a detected press in the tick domain. It then encodes the key and hands it to a consumer through a valid/ack handshake. It sits between the keypad pins and the system logic, and replaces free-running per-key debouncing with a single sequenced path.

Parameters:
SCAN_DIV, 27000, clk cycles per scan tick (1 ms at 27 MHz); legal range 2..65535
DEBOUNCE_TICKS, 4, consecutive matching tick samples required to accept a press or a release; legal range 2..15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
row_in  input  4  keypad rows, active-low (pulled up externally), already synchronised upstream
col_out  output  4  column drive, active-low, exactly one bit low at all times
key_code  output  4  encoded key = row*4 + col, held until the next accepted key
key_valid  output  1  key_code holds an unconsumed key
key_ack  input  1  consumer accepts key; sampled on clk
key_inhibit  output  1  high while a key is being debounced, held or released (scan frozen)
overrun  output  1  sticky: a key was accepted while key_valid was still high

Behaviour:
- Reset (async assert, sync release) values:
  - col_out=4'b1110, key_code=0, key_valid=0, overrun=0, key_inhibit=0
  - state=SCAN; tick counter and debounce counter = 0
- Tick generator: counts 0..SCAN_DIV-1 and wraps. tick=1 for one clk when count==SCAN_DIV-1. Free-running in all states.
- FSM states, acting on tick cycles only unless noted:
  - SCAN: if row_in!=4'hF, latch row pattern, set cnt=1, go to DEBOUNCE; col_out holds. Else rotate the active column 0->1->2->3->0 (col_out 1110->1101->1011->0111->1110).
  - DEBOUNCE:
    - if row_in equals the latched pattern: cnt++; when cnt reaches DEBOUNCE_TICKS go to PRESSED.
    - any mismatch (including release): cnt=0, rotate column, go to SCAN.
  - PRESSED (one clk, no tick needed):
    - row = index of the lowest zero bit of the latched pattern (multiple rows: lowest index wins).
    - Load key_code; set key_valid=1; cnt=0; go to REL_WAIT.
  - REL_WAIT: on tick, if row_in==4'hF then cnt++, else cnt=0. When cnt reaches DEBOUNCE_TICKS: cnt=0, rotate column, go to SCAN.
- key_inhibit = (state != SCAN), registered alongside state.
- Latency: key_valid rises exactly 1 clk after the tick on which cnt reaches DEBOUNCE_TICKS.
- Handshake:
  - key_ack with key_valid=1 clears key_valid next clk. key_ack with key_valid=0 is ignored.
  - key_ack also clears overrun.
- Overrun case (PRESSED while key_valid=1 and key_ack=0):
  - key_code is NOT overwritten; key_valid stays 1; overrun set to 1.
  - FSM still proceeds to REL_WAIT.
- Simultaneous key_ack and PRESSED in the same clk: the old key is consumed and the new key loads; key_valid stays 1; overrun=0.
- Reset mid-operation: everything returns to reset values immediately, including a pending key_valid. No partial key is ever reported.
- Width rules: the tick counter is 16 bits, the debounce counter 4 bits; neither may overflow within the legal parameter ranges.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE_TICKS=3.)
1. Reset, no keys pressed for 20 ticks -> col_out cycles 1110,1101,1011,0111,1110... changing every 4 clk; key_valid=0 and key_inhibit=0 throughout.
2. Hold row_in=4'b1011 while col_out=1101 (row2, col1) -> key_inhibit rises after the detect tick; key_valid=1 with key_code=9 one clk after the 3rd matching tick. Pulse key_ack -> key_valid=0 next clk.
3. Bounce: row2 low for 1 tick, then high, during col1 -> returns to SCAN with col_out=1011; key_valid never asserts.
4. Press 9, no ack, release for 3 ticks, press row0/col3 -> key_code stays 9, overrun=1. key_ack -> overrun=0 and key_valid=0.
5. key_ack asserted on the exact PRESSED clk of a second key (code 3) while key 9 is pending -> key_code=3, key_valid=1, overrun=0.
6. Assert rst_n=0 during DEBOUNCE and again during REL_WAIT with key_valid=1 -> all outputs at reset values within the same cycle; scanning resumes from col_out=1110.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one active-low column at a time, tick-domain
// debounce of press and release, and a valid/ack hand-off of the encoded key.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 27000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_inhibit,
  output logic       overrun
);

  localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_LAST   = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    REL_WAIT = 2'd3
  } state_t;

  // Lowest-index asserted (low) row wins when several rows are down.
  function automatic logic [1:0] lowest_zero(input logic [3:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] tick_cnt_r;
  logic        tick_s;
  logic [3:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0]  col_out_r, col_nxt_s, col_rot_s;
  logic [3:0]  latch_r, latch_nxt_s;
  logic [3:0]  key_code_r, code_nxt_s;
  logic        key_valid_r, valid_nxt_s;
  logic        overrun_r, ovr_nxt_s;
  logic        key_inhibit_r;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign cnt_inc_s = cnt_r + 4'd1;
  assign col_rot_s = {col_out_r[2:0], col_out_r[3]};

  // Free-running scan tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= 16'd0;
    end else if (tick_s) begin
      tick_cnt_r <= 16'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 16'd1;
    end
  end

  // Next-state, column, debounce and handshake logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    col_nxt_s   = col_out_r;
    latch_nxt_s = latch_r;
    code_nxt_s  = key_code_r;
    if (key_ack && key_valid_r) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = key_valid_r;
    end
    if (key_ack) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = overrun_r;
    end

    case (state_r)
      SCAN: begin
        if (tick_s && (row_in != 4'hF)) begin
          latch_nxt_s = row_in;
          cnt_nxt_s   = 4'd1;
          state_nxt_s = DEBOUNCE;
        end else if (tick_s) begin
          col_nxt_s = col_rot_s;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DEBOUNCE: begin
        if (tick_s && (row_in == latch_r)) begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == DB_LAST) begin
            state_nxt_s = PRESSED;
          end else begin
            state_nxt_s = DEBOUNCE;
          end
        end else if (tick_s) begin
          cnt_nxt_s   = 4'd0;
          col_nxt_s   = col_rot_s;
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = DEBOUNCE;
        end
      end
      PRESSED: begin
        // A pending, unacknowledged key is never overwritten.
        if (key_valid_r && !key_ack) begin
          ovr_nxt_s = 1'b1;
        end else begin
          code_nxt_s  = {lowest_zero(latch_r), col_index(col_out_r)};
          valid_nxt_s = 1'b1;
        end
        cnt_nxt_s   = 4'd0;
        state_nxt_s = REL_WAIT;
      end
      REL_WAIT: begin
        if (tick_s && (row_in == 4'hF) && (cnt_inc_s == DB_LAST)) begin
          cnt_nxt_s   = 4'd0;
          col_nxt_s   = col_rot_s;
          state_nxt_s = SCAN;
        end else if (tick_s && (row_in == 4'hF)) begin
          cnt_nxt_s = cnt_inc_s;
        end else if (tick_s) begin
          cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = REL_WAIT;
        end
      end
      default: begin
        cnt_nxt_s   = 4'd0;
        state_nxt_s = SCAN;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= SCAN;
      cnt_r         <= 4'd0;
      col_out_r     <= 4'b1110;
      latch_r       <= 4'hF;
      key_code_r    <= 4'd0;
      key_valid_r   <= 1'b0;
      overrun_r     <= 1'b0;
      key_inhibit_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      col_out_r     <= col_nxt_s;
      latch_r       <= latch_nxt_s;
      key_code_r    <= code_nxt_s;
      key_valid_r   <= valid_nxt_s;
      overrun_r     <= ovr_nxt_s;
      key_inhibit_r <= (state_nxt_s != SCAN);
    end
  end

  assign col_out     = col_out_r;
  assign key_code    = key_code_r;
  assign key_valid   = key_valid_r;
  assign overrun     = overrun_r;
  assign key_inhibit = key_inhibit_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a virtual keypad drives the rows,
// a behavioural model predicts every output each cycle.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic       key_ack = 1'b0;
  logic [3:0] col_out, key_code;
  logic       key_valid, key_inhibit, overrun;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_inhibit(key_inhibit), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle scan, 1 confirming press, 2 accept, 3 awaiting release.
  int         m_cyc, m_col, m_mode, m_cnt;
  logic [3:0] m_latch, m_code;
  logic       m_valid, m_ovr, m_inh;

  // Virtual keypad: one held key (kp_row < 0 means none).
  int kp_row = -1;
  int kp_col = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_col = 0; m_mode = 0; m_cnt = 0;
    m_latch = 4'hF; m_code = 4'd0; m_valid = 1'b0; m_ovr = 1'b0; m_inh = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] row, input logic ack);
    bit tick;
    int r;
    tick = ((m_cyc % SD) == SD - 1);
    m_cyc++;
    if (ack) m_ovr = 1'b0;
    m_valid = m_valid && !ack;
    case (m_mode)
      0: if (tick) begin
        if (row != 4'hF) begin m_latch = row; m_cnt = 1; m_mode = 1; end
        else m_col = (m_col + 1) % 4;
      end
      1: if (tick) begin
        if (row == m_latch) begin
          m_cnt++;
          if (m_cnt == DT) m_mode = 2;
        end else begin
          m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0;
        end
      end
      2: begin
        r = 3;
        for (int i = 3; i >= 0; i--) if (m_latch[i] == 1'b0) r = i;
        if (m_valid) m_ovr = 1'b1;
        else begin m_code = 4'(r * 4 + m_col); m_valid = 1'b1; end
        m_cnt = 0; m_mode = 3;
      end
      3: if (tick) begin
        if (row == 4'hF) m_cnt++; else m_cnt = 0;
        if (m_cnt == DT) begin m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0; end
      end
      default: m_mode = 0;
    endcase
    m_inh = (m_mode != 0);
  endtask

  function automatic logic [3:0] keypad_rows();
    logic [3:0] one;
    one = 4'h1;
    if (kp_row >= 0 && kp_col == m_col) return 4'hF & ~(one << kp_row);
    return 4'hF;
  endfunction

  task automatic check_all();
    logic [3:0] one;
    one = 4'h1;
    check_value("col_out", col_out, 4'hF ^ (one << m_col));
    check_value("key_code", key_code, m_code);
    check_value("key_valid", key_valid, m_valid);
    check_value("key_inhibit", key_inhibit, m_inh);
    check_value("overrun", overrun, m_ovr);
  endtask

  task automatic step(input logic ack, input logic noise);
    row_in = keypad_rows();
    if (noise) row_in = 4'($urandom_range(0, 15));
    key_ack = ack;
    model_step(row_in, key_ack);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int mode, input int budget, input string tag);
    int n;
    n = 0;
    while (m_mode != mode && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    check_value(tag, (m_mode == mode) ? 1 : 0, 1);
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check_value({tag, "_col"}, col_out, 4'b1110);
    check_value({tag, "_code"}, key_code, 0);
    check_value({tag, "_valid"}, key_valid, 0);
    check_value({tag, "_inh"}, key_inhibit, 0);
    check_value({tag, "_ovr"}, overrun, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    kp_row = -1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // 1: idle scanning, column advances every SD clocks
    repeat (4) step(1'b0, 1'b0);
    check_value("t1_col1", col_out, 4'b1101);
    repeat (76) step(1'b0, 1'b0);
    check_value("t1_wrap", col_out, 4'b1110);
    check_value("t1_valid", key_valid, 0);

    // 2: row2/col1 press, ack, release
    kp_row = 2; kp_col = 1;
    run_until(3, 200, "t2_reach");
    check_value("t2_code", key_code, 9);
    check_value("t2_valid", key_valid, 1);
    check_value("t2_inh", key_inhibit, 1);
    step(1'b1, 1'b0);
    check_value("t2_acked", key_valid, 0);
    kp_row = -1;
    run_until(0, 200, "t2_rel");

    // 3: one-tick bounce
    kp_row = 2; kp_col = 1;
    run_until(1, 200, "t3_det");
    kp_row = -1;
    run_until(0, 20, "t3_back");
    check_value("t3_col", col_out, 4'b1011);
    check_value("t3_valid", key_valid, 0);
    check_value("t3_inh", key_inhibit, 0);

    // 4: overrun
    kp_row = 2; kp_col = 1;
    run_until(3, 200, "t4_first");
    kp_row = -1;
    run_until(0, 200, "t4_rel1");
    kp_row = 0; kp_col = 3;
    run_until(2, 200, "t4_second");
    step(1'b0, 1'b0);
    check_value("t4_code", key_code, 9);
    check_value("t4_ovr", overrun, 1);
    check_value("t4_valid", key_valid, 1);
    step(1'b1, 1'b0);
    check_value("t4_ovr_clr", overrun, 0);
    check_value("t4_valid_clr", key_valid, 0);
    kp_row = -1;
    run_until(0, 200, "t4_rel2");

    // 5: ack coincides with accept of a new key
    kp_row = 2; kp_col = 1;
    run_until(3, 200, "t5_first");
    kp_row = -1;
    run_until(0, 200, "t5_rel1");
    kp_row = 0; kp_col = 3;
    run_until(2, 200, "t5_second");
    step(1'b1, 1'b0);
    check_value("t5_code", key_code, 3);
    check_value("t5_valid", key_valid, 1);
    check_value("t5_ovr", overrun, 0);
    step(1'b1, 1'b0);
    kp_row = -1;
    run_until(0, 200, "t5_rel2");

    // 6: reset during debounce and during release wait with a pending key
    kp_row = 2; kp_col = 1;
    run_until(1, 200, "t6_det");
    do_reset("t6_rst_db");
    kp_row = 2; kp_col = 1;
    run_until(3, 200, "t6_pend");
    check_value("t6_pend_valid", key_valid, 1);
    do_reset("t6_rst_rw");
    repeat (8) step(1'b0, 1'b0);

    // Randomized keypad activity with noise and sporadic acks
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        if ($urandom_range(0, 9) < 4) kp_row = -1;
        else begin
          kp_row = int'($urandom_range(0, 3));
          kp_col = int'($urandom_range(0, 3));
        end
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
    end
    key_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
